// File: rtl/issue_pkg.sv
// Shared opcodes, decoded-instruction class record and a small popcount helper
// for the issue queue.
package issue_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_mem;
    logic       is_ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_class_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Combinational decode of one instruction into the register/resource usage
// needed for issue-group hazard checks.
module instr_classify
  import issue_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls
);

  // Register usage and resource class by opcode; unknown opcodes are conservative
  always_comb begin
    cls           = '0;
    cls.rd        = instr[11:7];
    cls.rs1       = instr[19:15];
    cls.rs2       = instr[24:20];
    case (instr[6:0])
      OP_R:      begin cls.writes_rd = 1'b1; cls.uses_rs1 = 1'b1; cls.uses_rs2 = 1'b1; end
      OP_IMM:    begin cls.writes_rd = 1'b1; cls.uses_rs1 = 1'b1; end
      OP_LOAD:   begin cls.writes_rd = 1'b1; cls.uses_rs1 = 1'b1; cls.is_mem = 1'b1; end
      OP_STORE:  begin cls.uses_rs1 = 1'b1; cls.uses_rs2 = 1'b1; cls.is_mem = 1'b1; end
      OP_BRANCH: begin cls.uses_rs1 = 1'b1; cls.uses_rs2 = 1'b1; cls.is_ctrl = 1'b1; end
      OP_JAL:    begin cls.writes_rd = 1'b1; cls.is_ctrl = 1'b1; end
      OP_JALR:   begin cls.writes_rd = 1'b1; cls.uses_rs1 = 1'b1; cls.is_ctrl = 1'b1; end
      OP_LUI:    begin cls.writes_rd = 1'b1; end
      OP_AUIPC:  begin cls.writes_rd = 1'b1; end
      default:   begin cls.writes_rd = 1'b1; cls.uses_rs1 = 1'b1; cls.uses_rs2 = 1'b1; end
    endcase
  end

endmodule

// File: rtl/issue_queue.sv
// In-order instruction buffer that presents the longest hazard-free prefix
// from the head as an issue group of up to ISSUE_W lanes.
module issue_queue
  import issue_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [ISSUE_W-1:0]              in_mask,
  input  logic [ISSUE_W-1:0][31:0]        in_instr,
  input  logic [ISSUE_W-1:0][31:0]        in_pc,
  output logic                            in_ready,
  output logic [ISSUE_W-1:0]              out_valid,
  output logic [ISSUE_W-1:0][31:0]        out_instr,
  output logic [ISSUE_W-1:0][31:0]        out_pc,
  input  logic                            out_ready,
  output logic                            split,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  instr_class_t        w_cls   [ISSUE_W];
  logic [ISSUE_W-1:0]  w_haz   [ISSUE_W];
  logic [ISSUE_W-1:0]  w_valid;
  logic [CW-1:0]       w_grp_n;
  logic [CW-1:0]       w_push_n;
  logic [CW-1:0]       w_pop_n;
  logic [CW-1:0]       w_lim;
  logic                w_do_push;
  logic                w_do_pop;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    assign out_instr[k] = r_instr[r_head + PW'(k)];
    assign out_pc[k]    = r_pc[r_head + PW'(k)];

    instr_classify u_cls (
      .instr (out_instr[k]),
      .cls   (w_cls[k])
    );

    // Pairwise conflict of lane k against each older lane j of the group
    for (genvar j = 0; j < ISSUE_W; j++) begin : g_pair
      if (j < k) begin : g_chk
        assign w_haz[k][j] =
            (w_cls[j].writes_rd && (w_cls[j].rd != 5'd0) &&
             ((w_cls[k].uses_rs1 && (w_cls[k].rs1 == w_cls[j].rd)) ||
              (w_cls[k].uses_rs2 && (w_cls[k].rs2 == w_cls[j].rd)))) ||
            (w_cls[j].writes_rd && w_cls[k].writes_rd && (w_cls[k].rd != 5'd0) &&
             (w_cls[k].rd == w_cls[j].rd)) ||
            (w_cls[j].is_mem && w_cls[k].is_mem) ||
            w_cls[j].is_ctrl;
      end else begin : g_none
        assign w_haz[k][j] = 1'b0;
      end
    end
  end

  // Group prefix mask and lane counts for push, pop and split
  always_comb begin
    w_valid    = '0;
    w_grp_n    = '0;
    w_push_n   = '0;
    w_valid[0] = (r_count != {CW{1'b0}});
    for (int k = 1; k < ISSUE_W; k++) begin
      w_valid[k] = w_valid[k-1] && (CW'(k) < r_count) && !(|w_haz[k]);
    end
    w_grp_n  = CW'(popcount4(4'(w_valid)));
    w_push_n = CW'(popcount4(4'(in_mask)));
    if (r_count < CW'(ISSUE_W)) begin
      w_lim = r_count;
    end else begin
      w_lim = CW'(ISSUE_W);
    end
  end

  assign in_ready  = (CW'(DEPTH) - r_count) >= CW'(ISSUE_W);
  assign w_do_push = in_valid && in_ready;
  assign w_do_pop  = out_ready && w_valid[0];
  assign w_pop_n   = w_do_pop ? w_grp_n : {CW{1'b0}};
  assign out_valid = w_valid;
  assign split     = w_valid[0] && (w_grp_n < w_lim);
  assign count     = r_count;

  // Pointer and occupancy state; flush discards any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_n);
      r_tail  <= r_tail + (w_do_push ? PW'(w_push_n) : {PW{1'b0}});
      r_count <= r_count + (w_do_push ? w_push_n : {CW{1'b0}}) - w_pop_n;
    end
  end

  // Entry storage is not reset; in_mask is contiguous so lane l lands at tail+l
  always_ff @(posedge clk) begin
    for (int l = 0; l < ISSUE_W; l++) begin
      if (w_do_push && in_mask[l] && !flush) begin
        r_instr[r_tail + PW'(l)] <= in_instr[l];
        r_pc[r_tail + PW'(l)]    <= in_pc[l];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: scoreboard of pushed instructions
// compared against each popped group, plus directed group-shape checks.
module tb_issue_queue;

  localparam int IW = 2;
  localparam int DP = 8;
  localparam int CW = $clog2(DP+1);

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic [IW-1:0]        in_mask;
  logic [IW-1:0][31:0]  in_instr;
  logic [IW-1:0][31:0]  in_pc;
  logic                 in_ready;
  logic [IW-1:0]        out_valid;
  logic [IW-1:0][31:0]  out_instr;
  logic [IW-1:0][31:0]  out_pc;
  logic                 out_ready;
  logic                 split;
  logic [CW-1:0]        count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  issue_queue #(.ISSUE_W(IW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_mask   (in_mask),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .split     (split),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    addi = {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  // Drives one bundle across a clock edge and records accepted lanes
  task automatic push(input logic [IW-1:0] mask, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] pc0, input logic fl);
    in_valid    = 1'b1;
    in_mask     = mask;
    in_instr[0] = i0;
    in_instr[1] = i1;
    in_pc[0]    = pc0;
    in_pc[1]    = pc0 + 32'd4;
    flush       = fl;
    if (!fl) begin
      if (mask[0]) sb_q.push_back({pc0, i0});
      if (mask[1]) sb_q.push_back({pc0 + 32'd4, i1});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mask  = '0;
    flush    = 1'b0;
    if (fl) sb_q.delete();
  endtask

  // Compares every presented lane with the scoreboard, then consumes the group
  task automatic pop();
    for (int k = 0; k < IW; k++) begin
      if (out_valid[k]) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          sb_entry_t e;
          e = sb_q.pop_front();
          check_eq($sformatf("pc_l%0d", k), out_pc[k], e.pc);
          check_eq($sformatf("instr_l%0d", k), out_instr[k], e.instr);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_split", 32'(split), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Independent pair issues together
    push(2'b11, 32'h00500093, 32'h00100113, 32'h100, 1'b0);
    check_eq("indep_valid", 32'(out_valid), 32'd3);
    check_eq("indep_split", 32'(split), 32'd0);
    check_eq("indep_count", 32'(count), 32'd2);
    pop();
    check_eq("indep_count_after", 32'(count), 32'd0);
    check_eq("indep_valid_after", 32'(out_valid), 32'd0);

    // RAW split
    push(2'b11, 32'h00500093, 32'h00108113, 32'h200, 1'b0);
    check_eq("raw_valid", 32'(out_valid), 32'd1);
    check_eq("raw_split", 32'(split), 32'd1);
    pop();
    check_eq("raw_valid2", 32'(out_valid), 32'd1);
    check_eq("raw_pc2", out_pc[0], 32'h204);
    check_eq("raw_split2", 32'(split), 32'd0);
    pop();

    // Memory port split
    push(2'b11, 32'h00002183, 32'h00402203, 32'h300, 1'b0);
    check_eq("mem_valid", 32'(out_valid), 32'd1);
    check_eq("mem_split", 32'(split), 32'd1);
    pop();
    pop();

    // WAW split
    push(2'b11, 32'h00500093, 32'h00100093, 32'h400, 1'b0);
    check_eq("waw_valid", 32'(out_valid), 32'd1);
    pop();
    pop();

    // Branch ends its group; then flush wins over a same-cycle push
    push(2'b11, 32'h00000463, 32'h00100113, 32'h480, 1'b0);
    check_eq("ctrl_valid", 32'(out_valid), 32'd1);
    check_eq("ctrl_count", 32'(count), 32'd2);
    push(2'b11, 32'h00500093, 32'h00100113, 32'h4c0, 1'b1);
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_in_ready", 32'(in_ready), 32'd1);

    // Offset head so the fill wraps around storage
    push(2'b11, addi(9, 0, 1), addi(10, 0, 2), 32'h500, 1'b0);
    pop();
    for (int b = 0; b < 4; b++) begin
      check_eq($sformatf("fill_ready_%0d", b), 32'(in_ready), 32'd1);
      push(2'b11, addi(2*b+1, 0, b), addi(2*b+2, 0, b), 32'h1000 + 32'(8*b), 1'b0);
    end
    check_eq("full_count", 32'(count), 32'd8);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    for (int b = 0; b < 4; b++) begin
      check_eq($sformatf("drain_valid_%0d", b), 32'(out_valid), 32'd3);
      pop();
    end
    check_eq("drain_count", 32'(count), 32'd0);
    check_eq("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset mid-stream with count = 5
    push(2'b11, addi(1, 0, 1), addi(2, 0, 2), 32'h2000, 1'b0);
    push(2'b11, addi(3, 0, 3), addi(4, 0, 4), 32'h2008, 1'b0);
    push(2'b01, addi(5, 0, 5), addi(6, 0, 6), 32'h2010, 1'b0);
    check_eq("pre_rst_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
